// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW hazard detection and operand-forward select for an
// in-order pipeline. It tracks the destination registers of the DEPTH
// instructions in flight past issue (s1..sDEPTH). From these it derives a
// zero-latency stall and per-source forward selects for the instruction at s0.
//
// Optional feature macro: HAZARD_FORWARDING_EN
//   defined   : only loads that have not reached stage DEPTH stall; every
//               other match is forwarded from the matching stage.
//   undefined : any match stalls and the forward selects are tied to 0.

// Per-source match: finds the youngest valid tracked entry that writes the
// register this source reads. Register 0 never matches.
module hazard_src_match #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
) (
  input  logic [REG_AW-1:0]            rs,
  input  logic                         used,
  input  logic [DEPTH:1]               vld,
  input  logic [DEPTH:1][REG_AW-1:0]   rd,
  input  logic [DEPTH:1]               ld,
  output logic                         hit,
  output logic [2:0]                   k,
  output logic                         hit_ld
);

  // Scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    hit    = 1'b0;
    k      = 3'd0;
    hit_ld = 1'b0;
    for (int i = DEPTH; i >= 1; i--) begin
      if (used && vld[i] && (rd[i] == rs) && (rs != '0)) begin
        hit    = 1'b1;
        k      = 3'(i);
        hit_ld = ld[i];
      end
    end
  end

endmodule

module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_enable,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rs1,
  input  logic [REG_AW-1:0] iss_rs2,
  input  logic              iss_rs1_used,
  input  logic              iss_rs2_used,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              iss_we,
  input  logic              iss_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [2:0]        fwd_a_sel,
  output logic [2:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int NSRC = 2;

  // Tracked write-back stages; index 1 is the youngest
  logic [DEPTH:1]             vld_pipe;
  logic [DEPTH:1][REG_AW-1:0] ent_rd;
  logic [DEPTH:1]             ent_ld;

  // Source operands packed so both are handled by one generate loop
  logic [NSRC-1:0][REG_AW-1:0] src_rs;
  logic [NSRC-1:0]             src_used;
  logic [NSRC-1:0]             src_hit;
  logic [NSRC-1:0][2:0]        src_k;
  logic [NSRC-1:0]             src_ld;
  logic [NSRC-1:0]             src_stall;
  logic [NSRC-1:0][2:0]        src_fwd;

  // A killed or absent s0 instruction never stalls or forwards
  logic active;

  assign active   = iss_valid & ~flush;
  assign src_rs   = {iss_rs2, iss_rs1};
  assign src_used = {iss_rs2_used, iss_rs1_used};

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    hazard_src_match #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH)
    ) u_match (
      .rs     (src_rs[s]),
      .used   (src_used[s]),
      .vld    (vld_pipe),
      .rd     (ent_rd),
      .ld     (ent_ld),
      .hit    (src_hit[s]),
      .k      (src_k[s]),
      .hit_ld (src_ld[s])
    );

`ifdef HAZARD_FORWARDING_EN
    // A load only has its data at stage DEPTH; before that the consumer waits.
    // Every other match is bypassed from the stage that holds the result.
    assign src_stall[s] = active & src_hit[s] & src_ld[s] & (src_k[s] < 3'(DEPTH));
    assign src_fwd[s]   = (active & src_hit[s] & ~src_stall[s]) ? src_k[s] : 3'd0;
`else
    // No bypass network: any in-flight producer blocks the read
    assign src_stall[s] = active & src_hit[s];
    assign src_fwd[s]   = 3'd0;
`endif
  end

`ifndef HAZARD_FORWARDING_EN
  // Stage index and load flag only steer forwarding, which is absent here
  logic unused_fwd_info;
  assign unused_fwd_info = ^{src_k, src_ld};
`endif

  assign stall     = |src_stall;
  assign fwd_a_sel = src_fwd[0];
  assign fwd_b_sel = src_fwd[1];

  // Advance the tracked stages; flush kills everything younger than stage
  // DEPTH, while the instruction moving into stage DEPTH still commits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      ent_rd   <= '0;
      ent_ld   <= '0;
    end else if (clk_enable) begin
      vld_pipe[1] <= iss_valid & iss_we & ~stall & ~flush;
      ent_rd[1]   <= iss_rd;
      ent_ld[1]   <= iss_is_load;
      for (int k = 2; k <= DEPTH; k++) begin
        if (flush && (k < DEPTH))
          vld_pipe[k] <= 1'b0;
        else
          vld_pipe[k] <= vld_pipe[k-1];
        ent_rd[k] <= ent_rd[k-1];
        ent_ld[k] <= ent_ld[k-1];
      end
    end
  end

  // Count stalled cycles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (clk_enable && stall && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
module tb_hazard_scoreboard;
  localparam int AW   = 5;
  localparam int D    = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_enable = 1'b0;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
  logic          iss_rs1_used = 1'b0, iss_rs2_used = 1'b0;
  logic          iss_we = 1'b0, iss_is_load = 1'b0, flush = 1'b0;
  logic          stall;
  logic [2:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(AW), .DEPTH(D), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_enable   (clk_enable),
    .iss_valid    (iss_valid),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_rs1_used (iss_rs1_used),
    .iss_rs2_used (iss_rs2_used),
    .iss_rd       (iss_rd),
    .iss_we       (iss_we),
    .iss_is_load  (iss_is_load),
    .flush        (flush),
    .stall        (stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_count  (stall_count)
  );

  typedef struct packed {
    logic          st;
    logic [2:0]    fa;
    logic [2:0]    fb;
    logic [CW-1:0] cnt;
  } exp_t;

  // Reference model: a list of in-flight writes, each aged by cycles since issue
  typedef struct {
    int rd;
    bit ld;
    int age;
  } rec_t;

  exp_t expq[$];
  rec_t infl[$];
  int   m_cnt = 0;
  bit   m_stall = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Youngest in-flight writer of register rs (age 0 = none)
  function automatic void youngest(input int rs, input bit used, output int age, output bit ld);
    age = 0;
    ld  = 1'b0;
    if (used && rs != 0)
      foreach (infl[i])
        if (infl[i].rd == rs && (age == 0 || infl[i].age < age)) begin
          age = infl[i].age;
          ld  = infl[i].ld;
        end
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    int ya, yb;
    bit la, lb, sa, sb;
    e = '0;
    e.cnt = CW'(m_cnt);
    youngest(int'(iss_rs1), iss_rs1_used, ya, la);
    youngest(int'(iss_rs2), iss_rs2_used, yb, lb);
    sa = 1'b0;
    sb = 1'b0;
    if (iss_valid && !flush) begin
`ifdef HAZARD_FORWARDING_EN
      sa = (ya != 0) && la && (ya < D);
      sb = (yb != 0) && lb && (yb < D);
      e.fa = (ya != 0 && !sa) ? 3'(ya) : 3'd0;
      e.fb = (yb != 0 && !sb) ? 3'(yb) : 3'd0;
`else
      sa = (ya != 0);
      sb = (yb != 0);
`endif
      e.st = sa || sb;
    end
    return e;
  endfunction

  function automatic void model_edge();
    rec_t nq[$];
    rec_t r;
    rec_t n;
    if (!clk_enable) return;
    if (m_stall && m_cnt < CMAX) m_cnt++;
    foreach (infl[i]) begin
      r = infl[i];
      r.age++;
      if (r.age <= D && !(flush && r.age < D)) nq.push_back(r);
    end
    if (!flush && iss_valid && iss_we && !m_stall) begin
      n.rd = int'(iss_rd);
      n.ld = iss_is_load;
      n.age = 1;
      nq.push_back(n);
    end
    infl = nq;
  endfunction

  task automatic set_iss(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                         input int rd, input bit we, input bit ld, input bit fl, input bit en);
    iss_valid    = v;
    iss_rs1      = AW'(rs1);
    iss_rs2      = AW'(rs2);
    iss_rs1_used = u1;
    iss_rs2_used = u2;
    iss_rd       = AW'(rd);
    iss_we       = we;
    iss_is_load  = ld;
    flush        = fl;
    clk_enable   = en;
  endtask

  // One cycle from posedge+1: queue the model's expectation, optionally check
  // fixed values at the negedge, then advance the model on the next posedge
  task automatic step(input int es, input int efa, input int efb, input int ec);
    exp_t e;
    e = model_eval();
    expq.push_back(e);
    m_stall = e.st;
    @(negedge clk);
    if (es  >= 0) chk("dir_stall", int'(stall), es);
    if (efa >= 0) chk("dir_fwd_a", int'(fwd_a_sel), efa);
    if (efb >= 0) chk("dir_fwd_b", int'(fwd_b_sel), efb);
    if (ec  >= 0) chk("dir_count", int'(stall_count), ec);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asynchronous reset pulse starting mid-cycle; outputs must drop at once
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_stall", int'(stall), 0);
    chk("rst_fwd_a", int'(fwd_a_sel), 0);
    chk("rst_fwd_b", int'(fwd_b_sel), 0);
    chk("rst_count", int'(stall_count), 0);
    infl.delete();
    m_cnt = 0;
    #1;
    rst_n = 1'b1;
    set_iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented output cycle against the queued model value
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("mon_stall", int'(stall), int'(e.st));
      chk("mon_fwd_a", int'(fwd_a_sel), int'(e.fa));
      chk("mon_fwd_b", int'(fwd_b_sel), int'(e.fb));
      chk("mon_count", int'(stall_count), int'(e.cnt));
    end
  end

  initial begin
    #1;
    do_reset();

    // Write r5, then read it back-to-back
    set_iss(1, 0, 0, 0, 0, 5, 1, 0, 0, 1); step(0, 0, 0, 0);
    set_iss(1, 5, 0, 1, 0, 0, 0, 0, 0, 1);
`ifdef HAZARD_FORWARDING_EN
    step(0, 1, 0, 0); step(0, 2, 0, 0); step(0, 3, 0, 0); step(0, 0, 0, 0);
`else
    step(1, 0, 0, 0); step(1, 0, 0, 1); step(1, 0, 0, 2); step(0, 0, 0, 3);
`endif

    // Register 0 never hazards
    do_reset();
    set_iss(1, 0, 0, 0, 0, 0, 1, 0, 0, 1); step(0, 0, 0, 0);
    set_iss(1, 0, 0, 1, 1, 0, 0, 0, 0, 1); step(0, 0, 0, 0);

    // ALU producer r7 read on rs2
    do_reset();
    set_iss(1, 0, 0, 0, 0, 7, 1, 0, 0, 1); step(0, 0, 0, 0);
    set_iss(1, 0, 7, 0, 1, 0, 0, 0, 0, 1);
`ifdef HAZARD_FORWARDING_EN
    step(0, 0, 1, 0); step(0, 0, 2, 0);
`else
    step(1, 0, 0, 0); step(1, 0, 0, 1);
`endif

    // Load producer r9 read on rs1
    do_reset();
    set_iss(1, 0, 0, 0, 0, 9, 1, 1, 0, 1); step(0, 0, 0, 0);
    set_iss(1, 9, 0, 1, 0, 0, 0, 0, 0, 1);
`ifdef HAZARD_FORWARDING_EN
    step(1, 0, 0, 0); step(1, 0, 0, 1); step(0, 3, 0, 2);
`else
    step(1, 0, 0, 0); step(1, 0, 0, 1); step(1, 0, 0, 2); step(0, 0, 0, 3);
`endif

    // r4 in entries 1 and 3, r8 in entry 2; gated cycle, then flush
    do_reset();
    set_iss(1, 0, 0, 0, 0, 4, 1, 0, 0, 1); step(0, 0, 0, 0);
    set_iss(1, 0, 0, 0, 0, 8, 1, 0, 0, 1); step(0, 0, 0, 0);
    set_iss(1, 0, 0, 0, 0, 4, 1, 0, 0, 1); step(0, 0, 0, 0);
    set_iss(1, 4, 0, 1, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_FORWARDING_EN
    step(0, 1, 0, 0);
`else
    step(1, 0, 0, 0);
`endif
    set_iss(1, 4, 0, 1, 0, 0, 0, 0, 1, 1); step(0, 0, 0, 0);
    set_iss(1, 4, 8, 1, 1, 0, 0, 0, 0, 1);
`ifdef HAZARD_FORWARDING_EN
    step(0, 0, 3, 0);
`else
    step(1, 0, 0, 0);
`endif

    // Long self-dependent load stream saturates the counter
    do_reset();
    set_iss(1, 3, 0, 1, 0, 3, 1, 1, 0, 1);
    repeat (40) step(-1, -1, -1, -1);
    set_iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step(0, 0, 0, CMAX);
    set_iss(1, 0, 0, 0, 0, 6, 1, 1, 0, 1); step(0, 0, 0, CMAX);
    set_iss(1, 6, 0, 1, 0, 0, 0, 0, 0, 1);
    #1 chk("pre_reset_stall", int'(stall), 1);
    do_reset();
    set_iss(1, 6, 0, 1, 0, 0, 0, 0, 0, 1); step(0, 0, 0, 0);

    // Randomized traffic over a small register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 99) do_reset();
      set_iss($urandom_range(0, 9) < 8,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0);
      step(-1, -1, -1, -1);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register address width.
REQ-002 SHALL have parameter DEPTH, default 3, range 1..7, meaning number of in-flight write-back stages tracked (s1..sDEPTH).
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall-statistics counter width.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clk_enable  input  1  advances all state only when high.
REQ-006 SHALL have port iss_valid  input  1  a decoded instruction is presented at s0.
REQ-007 SHALL have ports iss_rs1, iss_rs2  input  REG_AW  source register addresses.
REQ-008 SHALL have ports iss_rs1_used, iss_rs2_used  input  1  source is actually read.
REQ-009 SHALL have ports iss_rd  input  REG_AW and iss_we  input  1  destination and write-enable.
REQ-010 SHALL have port iss_is_load  input  1  result is produced only at stage DEPTH.
REQ-011 SHALL have port flush  input  1  kill the s0 instruction and all tracked stages younger than DEPTH.
REQ-012 SHALL have port stall  output  1  hold s0 and insert a bubble.
REQ-013 SHALL have ports fwd_a_sel, fwd_b_sel  output  3  0 = register file, k = forward from stage k.
REQ-014 SHALL have port stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-015 SHALL keep a DEPTH-entry shift register of {valid, rd, is_load}; entry 1 is youngest.
REQ-016 SHALL, each enabled cycle, shift entry k to k+1 and discard entry DEPTH.
REQ-017 SHALL load entry 1 with {iss_valid & iss_we & ~stall & ~flush, iss_rd, iss_is_load}.
REQ-018 SHALL treat a match on source s as: iss_rs_s_used, entry valid, entry rd == iss_rs_s, rd != 0; register 0 never creates a hazard.
REQ-019 SHALL, when several entries match, use the youngest (lowest k) for the hazard and forward decisions.
REQ-020 SHALL be combinational on stall and fwd_*_sel from the current inputs and entries, with zero-cycle latency.
REQ-021 SHALL force stall = 0 and fwd_*_sel = 0 when iss_valid = 0 or flush = 1.
REQ-022 SHALL, on flush, clear valid in entries 1..DEPTH-1 at the clock edge, and SHALL keep entry DEPTH committing; flush has priority over stall.
REQ-023 SHALL increment stall_count by 1 each enabled cycle with stall = 1, saturating at all-ones with no wrap.
REQ-024 SHALL, with clk_enable = 0, hold all state; outputs still reflect current inputs.

Reset
REQ-025 SHALL, while rst_n = 0, clear all entry valid bits, rd and is_load to 0, and stall_count to 0, independent of clk.
REQ-026 SHALL, after reset, have stall = 0 and fwd_*_sel = 0 for any input that matches no entry; a reset mid-stall discards the pending instruction's hazard.

Configuration
REQ-027 SHALL implement the macro HAZARD_FORWARDING_EN.
REQ-028 SHALL, when HAZARD_FORWARDING_EN is defined, stall only on a matching entry with is_load = 1 at k < DEPTH; any other match SHALL drive fwd_s_sel = k with no stall.
REQ-029 SHALL, when HAZARD_FORWARDING_EN is undefined, stall on any match and tie fwd_a_sel and fwd_b_sel to 0.

Verification
REQ-030 SHALL cover this case, no forwarding: issue rd=5 we, then rs1=5 used -> stall=1 for 3 cycles, then 0; stall_count = 3.
REQ-031 SHALL cover this case: issue rd=0 we, then rs1=0 and rs2=0 used -> stall=0 and fwd_a_sel = fwd_b_sel = 0.
REQ-032 SHALL cover this case, forwarding on: ALU rd=7, then rs2=7 -> stall=0 and fwd_b_sel=1; one cycle later on a repeat read -> fwd_b_sel=2.
REQ-033 SHALL cover this case, forwarding on: load rd=9, then rs1=9 -> stall=1, 1 for two cycles, then fwd_a_sel=3 and stall=0.
REQ-034 SHALL cover this case: rd=4 in entries 1 and 3, read rs1=4 -> forwarding selects 1; flush in the same cycle -> stall=0 and entries 1,2 invalid next cycle.
REQ-035 SHALL cover this case: CNT_W=4 with a continuous hazard for 20 cycles -> stall_count=15 (saturated); assert rst_n=0 mid-hazard -> all outputs 0 immediately.
